sc_stream_decoder: RTL and testbench
====================================

// Module: sc_stream_decoder
// PURPOSE
//  Stochastic-to-binary decoder for the SC FIR datapath; it is the receiving end of the SC number generators.
//  Counts '1' bits of a serial stochastic bitstream over a window of 2^N accepted bits.
//  Emits the window result as an N+1-bit binary word, the same width as the BC_FIR in/out bus, so SC and BC FIR outputs compare directly.
//  Sits after the SC FIR MUX-adder tree, clocked at the bitstream rate.
// PARAMETERS
//  N           12  window = 2^N bits; out width N+1
//  BIPOLAR     1   1: out = ones - 2^(N-1), two's complement; 0: out = ones, unsigned
//  CONTINUOUS  1   1: start next window immediately; 0: return to IDLE after each result
// PORTS
//  clock        in   1    bitstream clock (single clock domain)
//  reset        in   1    asynchronous, active-high
//  bit_in       in   1    stochastic bit, sampled only when bit_valid=1
//  bit_valid    in   1    qualifies bit_in this cycle
//  frame_start  in   1    synchronous window (re)start; sampled every cycle
//  out          out  N+1  last completed window result; held until next result
//  out_valid    out  1    1-cycle pulse when out updates
//  busy         out  1    1 while state==ACCUM
// BEHAVIOUR
//  Reset (async, any time, including mid-window):
//   state=IDLE, bit_cnt=0, ones_cnt=0, out=0, out_valid=0, busy=0.
//  State ACCUM:
//   - Accepted bit: each cycle with bit_valid=1. bit_cnt += 1; ones_cnt += bit_in.
//   - bit_cnt is N bits. ones_cnt is N+1 bits; its range 0..2^N never overflows.
//   - Window complete: the accepted bit on which bit_cnt==2^N-1.
//   - Next edge on completion: out <= f(ones_cnt_next); out_valid <= 1; both counters <= 0.
//   - Latency: out_valid asserts 1 clock after the final bit is accepted.
//   - f (BIPOLAR=1): ones - 2^(N-1), range [-2^(N-1), +2^(N-1)]. Fits in N+1 signed, so no saturation.
//   - f (BIPOLAR=0): ones, range [0, 2^N].
//   - After completion: CONTINUOUS=1 -> stay in ACCUM; CONTINUOUS=0 -> go to IDLE.
//   - bit_valid=0: counters hold. Gaps of any length are allowed.
//  State IDLE: bits are ignored; frame_start=1 -> ACCUM.
//  frame_start=1 (any state):
//   - Counters clear.
//   - If bit_valid=1 in the same cycle, that bit is counted as bit 0 of the new window.
//   - A partial window is discarded: no out_valid, out unchanged.
//  Priority:
//   - frame_start on the window-completing cycle: frame_start wins. No result is emitted; the bit starts a new window.
//   - reset beats everything.
//  out_valid is low on every cycle other than the completion pulse. out is registered, not combinational.
//  Decoded mapping for verification (BIPOLAR=1): value x = out / 2^(N-1), with x in [-1, 1].
// STRUCTURE
//  Shared package sc_pkg:
//   - SC_N = 12 and SC_WIN = 1<<SC_N.
//   - typedef enum logic {IDLE, ACCUM} sc_dec_state_t.
//   - typedef logic signed [SC_N:0] sc_word_t, shared with BC_FIR out.
//  Sub-module sc_window_counter:
//   - Contains bit_cnt and ones_cnt.
//   - Inputs: clear, inc_en, bit.
//   - Outputs: ones, last. last=1 when bit_cnt==2^N-1 && inc_en.
//  Top level holds the FSM, the output mapping and the out/out_valid registers.
// TESTING (N=12 unless noted)
//  1. frame_start, then 4096 ones, bit_valid=1 throughout.
//     -> out_valid exactly 1 cycle after the last bit.
//     -> BIPOLAR=1: out=13'sd2048. BIPOLAR=0: out=13'd4096.
//  2. 4096 zeros, BIPOLAR=1 -> out=-2048 (13'h1800).
//     Alternating 1,0 -> out=0. Second window in CONTINUOUS=1 -> out_valid again after 4096 more bits.
//  3. bit_valid toggling every cycle, all ones.
//     -> out_valid ~8192 cycles after frame_start; out=2048; counters frozen during gaps.
//  4. frame_start re-asserted at accepted bit 100, then 4096 ones.
//     -> no pulse at the old boundary; one pulse with out=2048.
//     Also: frame_start on the completing bit -> no pulse.
//  5. reset pulse mid-window (bit 2000), released asynchronously.
//     -> out=0, out_valid=0, busy=0 immediately; IDLE ignores bits until frame_start.
//  6. N=4, CONTINUOUS=0, random stream vs a reference popcount over 16 bits.
//     -> out matches for every window; busy drops after each result.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing FIR datapath: window size,
// decoder state encoding and the binary word type shared with the BC FIR bus.
package sc_pkg;

    localparam int SC_N   = 12;
    localparam int SC_WIN = 1 << SC_N;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } sc_dec_state_t;

    typedef logic signed [SC_N:0] sc_word_t;

endpackage

// File: rtl/sc_window_counter.sv
// Window counter for the stochastic decoder: counts accepted bits and ones
// over a 2^N-bit window and flags the window-completing bit.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int N = SC_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc_en,
    input  logic         bit_in,
    output logic [N:0]   ones,
    output logic         last
);

    logic [N-1:0] bit_cnt_r;
    logic [N:0]   ones_cnt_r;

    // Ones count including the current bit, and window-completion flag
    always_comb begin
        ones = ones_cnt_r;
        last = 1'b0;
        if (inc_en) begin
            ones = ones_cnt_r + (N+1)'(bit_in);
            last = (bit_cnt_r == {N{1'b1}});
        end else begin
            ones = ones_cnt_r;
            last = 1'b0;
        end
    end

    // Counter registers; a clear with a valid bit seeds the window with that bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_r  <= {N{1'b0}};
            ones_cnt_r <= {(N+1){1'b0}};
        end else if (clear) begin
            bit_cnt_r  <= N'(inc_en);
            ones_cnt_r <= (N+1)'(inc_en & bit_in);
        end else if (inc_en && last) begin
            bit_cnt_r  <= {N{1'b0}};
            ones_cnt_r <= {(N+1){1'b0}};
        end else if (inc_en) begin
            bit_cnt_r  <= bit_cnt_r + N'(1);
            ones_cnt_r <= ones;
        end else begin
            bit_cnt_r  <= bit_cnt_r;
            ones_cnt_r <= ones_cnt_r;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^N accepted bits and
// emits a registered N+1-bit result (bipolar or unipolar) with a 1-cycle valid.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int N          = SC_N,
    parameter bit BIPOLAR    = 1'b1,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         frame_start,
    output logic [N:0]   out,
    output logic         out_valid,
    output logic         busy
);

    localparam logic [N:0] BIAS = (N+1)'(1) << (N-1);

    sc_dec_state_t state_r;
    sc_dec_state_t state_next_s;
    logic          inc_en_s;
    logic          complete_s;
    logic [N:0]    ones_s;
    logic          last_s;
    logic [N:0]    result_s;
    logic [N:0]    out_r;
    logic          out_valid_r;
    logic          busy_r;

    // Bits count only while accumulating, or as bit 0 of a freshly started window
    always_comb begin
        inc_en_s = 1'b0;
        if (frame_start || (state_r == ACCUM)) begin
            inc_en_s = bit_valid;
        end else begin
            inc_en_s = 1'b0;
        end
    end

    sc_window_counter #(
        .N (N)
    ) u_window_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (frame_start),
        .inc_en (inc_en_s),
        .bit_in (bit_in),
        .ones   (ones_s),
        .last   (last_s)
    );

    // Next-state logic; frame_start overrides a completing bit
    always_comb begin
        state_next_s = state_r;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    state_next_s = ACCUM;
                end else if (last_s) begin
                    complete_s   = 1'b1;
                    state_next_s = CONTINUOUS ? ACCUM : IDLE;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            default: begin
                state_next_s = IDLE;
                complete_s   = 1'b0;
            end
        endcase
    end

    // Result mapping: bipolar subtracts half the window, range fits N+1 signed
    always_comb begin
        result_s = ones_s;
        if (BIPOLAR) begin
            result_s = ones_s - BIAS;
        end else begin
            result_s = ones_s;
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            out_r       <= {(N+1){1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= complete_s;
            busy_r      <= (state_next_s == ACCUM);
            if (complete_s) begin
                out_r <= result_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder: three configurations share one
// stimulus stream and are compared every cycle against a window-popcount model.
module tb_sc_stream_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        frame_start;
    logic [12:0] out_b;
    logic [12:0] out_u;
    logic [4:0]  out_s;
    logic        vld_b, vld_u, vld_s;
    logic        busy_b, busy_u, busy_s;

    int    n_total = 0;
    int    n_bad   = 0;
    string phase   = "init";

    localparam int MN    [3] = '{12, 12, 4};
    localparam bit MBIP  [3] = '{1'b1, 1'b0, 1'b0};
    localparam bit MCONT [3] = '{1'b1, 1'b1, 1'b0};

    bit          m_active [3];
    int          m_len    [3];
    bit          m_bits   [3][4096];
    logic [31:0] m_out    [3];
    bit          m_vld    [3];

    sc_stream_decoder #(.N(12), .BIPOLAR(1'b1), .CONTINUOUS(1'b1)) dut_b (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out(out_b), .out_valid(vld_b), .busy(busy_b));

    sc_stream_decoder #(.N(12), .BIPOLAR(1'b0), .CONTINUOUS(1'b1)) dut_u (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out(out_u), .out_valid(vld_u), .busy(busy_u));

    sc_stream_decoder #(.N(4), .BIPOLAR(1'b0), .CONTINUOUS(1'b0)) dut_s (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out(out_s), .out_valid(vld_s), .busy(busy_s));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Window result from the stored bits: popcount, optional bipolar offset, wrapped to N+1 bits
    function automatic logic [31:0] window_value(input int k);
        int ones = 0;
        int v;
        for (int i = 0; i < m_len[k]; i++) ones += int'(m_bits[k][i]);
        v = MBIP[k] ? ones - (1 << (MN[k] - 1)) : ones;
        return 32'(v) & ((32'd1 << (MN[k] + 1)) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_active[k] = 1'b0;
            m_len[k]    = 0;
            m_out[k]    = 32'd0;
            m_vld[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input bit fs, input bit v, input bit b);
        for (int k = 0; k < 3; k++) begin
            m_vld[k] = 1'b0;
            if (fs) begin
                m_active[k] = 1'b1;
                m_len[k]    = 0;
                if (v) begin
                    m_bits[k][m_len[k]] = b;
                    m_len[k]++;
                end
            end else if (m_active[k] && v) begin
                m_bits[k][m_len[k]] = b;
                m_len[k]++;
                if (m_len[k] == (1 << MN[k])) begin
                    m_out[k]    = window_value(k);
                    m_vld[k]    = 1'b1;
                    m_len[k]    = 0;
                    m_active[k] = MCONT[k];
                end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] g_out, g_vld, g_busy;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin g_out = 32'(out_b); g_vld = 32'(vld_b); g_busy = 32'(busy_b); end
                1:       begin g_out = 32'(out_u); g_vld = 32'(vld_u); g_busy = 32'(busy_u); end
                default: begin g_out = 32'(out_s); g_vld = 32'(vld_s); g_busy = 32'(busy_s); end
            endcase
            check_eq($sformatf("%s_i%0d_out", phase, k), g_out, m_out[k]);
            check_eq($sformatf("%s_i%0d_vld", phase, k), g_vld, 32'(m_vld[k]));
            check_eq($sformatf("%s_i%0d_busy", phase, k), g_busy, 32'(m_active[k]));
        end
    endtask

    task automatic cyc(input bit fs, input bit v, input bit b);
        frame_start = fs;
        bit_valid   = v;
        bit_in      = b;
        @(posedge clock);
        model_step(fs, v, b);
        #1;
        check_all();
    endtask

    initial begin
        reset       = 1'b1;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        phase = "rst";
        check_all();
        reset = 1'b0;

        // all ones: +1.0 bipolar, full scale unipolar
        phase = "t1";
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4096) cyc(1'b0, 1'b1, 1'b1);
        check_eq("t1_out_b", 32'(out_b), 32'h0800);
        check_eq("t1_out_u", 32'(out_u), 32'd4096);
        check_eq("t1_vld_b", 32'(vld_b), 32'd1);

        // continuous windows: all zeros, then alternating
        phase = "t2";
        repeat (4096) cyc(1'b0, 1'b1, 1'b0);
        check_eq("t2_zero_out_b", 32'(out_b), 32'h1800);
        for (int i = 0; i < 4096; i++) cyc(1'b0, 1'b1, (i % 2) == 0);
        check_eq("t2_alt_out_b", 32'(out_b), 32'h0000);
        check_eq("t2_alt_vld_b", 32'(vld_b), 32'd1);

        // valid toggling every cycle
        phase = "t3";
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8192; i++) cyc(1'b0, (i % 2) == 1, 1'b1);
        check_eq("t3_out_b", 32'(out_b), 32'h0800);
        check_eq("t3_vld_b", 32'(vld_b), 32'd1);

        // restart at bit 100, then restart on the completing bit
        phase = "t4";
        cyc(1'b1, 1'b0, 1'b0);
        repeat (100) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (4095) cyc(1'b0, 1'b1, 1'b1);
        check_eq("t4_out_b", 32'(out_b), 32'h0800);
        check_eq("t4_vld_b", 32'(vld_b), 32'd1);
        repeat (4095) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check_eq("t4_collide_vld_b", 32'(vld_b), 32'd0);
        check_eq("t4_collide_out_b", 32'(out_b), 32'h0800);

        // asynchronous reset mid-window, then IDLE ignores bits
        phase = "t5";
        cyc(1'b1, 1'b0, 1'b0);
        repeat (2000) cyc(1'b0, 1'b1, 1'($urandom));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        phase = "t5rst";
        check_all();
        check_eq("t5_busy_b", 32'(busy_b), 32'd0);
        #1;
        reset = 1'b0;
        phase = "t5idle";
        repeat (50) cyc(1'b0, 1'b1, 1'b1);

        // random stream with random restarts
        phase = "t6";
        cyc(1'b1, 1'b1, 1'($urandom));
        for (int i = 0; i < 6000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
